// File: rtl/aud_pkg.sv
// Shared types and default widths for the audio recorder/player datapath.
package aud_pkg;
    localparam int AUD_SAMPLE_W = 16;
    localparam int AUD_ADDR_W   = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_WRITE,
        S_PAUSE
    } rec_state_t;
endpackage

// File: rtl/aud_i2s_shift.sv
// I2S single-channel deserializer: LRC edge detect, bit counter and MSB-first shifter.
module aud_i2s_shift
    import aud_pkg::*;
#(
    parameter int   SAMPLE_W    = AUD_SAMPLE_W,
    parameter logic CAPTURE_LRC = 1'b0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_lrc,
    input  logic                i_data,
    input  logic                i_en,
    output logic                o_edge,
    output logic                o_done,
    output logic [SAMPLE_W-1:0] o_sample
);
    localparam int CNT_W = $clog2(SAMPLE_W);

    logic                lrc_d_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [SAMPLE_W-2:0] shift_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrc_d_reg <= 1'b0;
            cnt_reg   <= '0;
            shift_reg <= '0;
        end else begin
            lrc_d_reg <= i_lrc;
            if (i_en) begin
                shift_reg <= o_sample[SAMPLE_W-2:0];
                cnt_reg   <= cnt_reg + CNT_W'(1);
            end else begin
                cnt_reg   <= '0;
            end
        end
    end

    // The final bit is merged combinationally so the full word is ready on o_done.
    assign o_sample = {shift_reg, i_data};
    assign o_done   = i_en && (cnt_reg == CNT_W'(SAMPLE_W - 1));
    assign o_edge   = (i_lrc != lrc_d_reg) && (i_lrc == CAPTURE_LRC);
endmodule

// File: rtl/aud_recorder.sv
// Record/pause/stop controller: captures one I2S channel and writes each sample to SRAM.
module aud_recorder
    import aud_pkg::*;
#(
    parameter int                SAMPLE_W    = AUD_SAMPLE_W,
    parameter int                ADDR_W      = AUD_ADDR_W,
    parameter logic [ADDR_W-1:0] MAX_ADDR    = {ADDR_W{1'b1}},
    parameter logic              CAPTURE_LRC = 1'b0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_lrc,
    input  logic                i_data,
    input  logic                i_start,
    input  logic                i_pause,
    input  logic                i_stop,
    output logic [ADDR_W-1:0]   o_address,
    output logic [SAMPLE_W-1:0] o_data,
    output logic                o_wr,
    output logic                o_busy,
    output logic                o_paused,
    output logic                o_full,
    output logic [ADDR_W-1:0]   o_last_addr
);
    rec_state_t          state_reg, state_next;
    logic [ADDR_W-1:0]   address_reg, address_next;
    logic [ADDR_W-1:0]   last_reg, last_next;
    logic [SAMPLE_W-1:0] data_reg, data_next;
    logic                full_reg, full_next;

    logic                shift_en;
    logic                cap_edge;
    logic                shift_done;
    logic [SAMPLE_W-1:0] shift_sample;

    assign shift_en = (state_reg == S_SHIFT);

    aud_i2s_shift #(
        .SAMPLE_W    (SAMPLE_W),
        .CAPTURE_LRC (CAPTURE_LRC)
    ) u_shift (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_lrc    (i_lrc),
        .i_data   (i_data),
        .i_en     (shift_en),
        .o_edge   (cap_edge),
        .o_done   (shift_done),
        .o_sample (shift_sample)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= S_IDLE;
            address_reg <= '0;
            last_reg    <= '0;
            data_reg    <= '0;
            full_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            address_reg <= address_next;
            last_reg    <= last_next;
            data_reg    <= data_next;
            full_reg    <= full_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        address_next = address_reg;
        last_next    = last_reg;
        data_next    = data_reg;
        full_next    = full_reg;
        case (state_reg)
            S_IDLE: begin
                if (i_start && !i_stop) begin
                    state_next   = S_WAIT;
                    address_next = '0;
                    last_next    = '0;
                    full_next    = 1'b0;
                end
            end
            S_WAIT: begin
                if (i_stop)        state_next = S_IDLE;
                else if (i_pause)  state_next = S_PAUSE;
                else if (cap_edge) state_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (i_stop)       state_next = S_IDLE;
                else if (i_pause) state_next = S_PAUSE;
                else if (shift_done) begin
                    state_next = S_WRITE;
                    data_next  = shift_sample;
                end
            end
            S_WRITE: begin
                // The write always completes; stop/pause only choose where to go afterwards.
                last_next = address_reg;
                if (address_reg == MAX_ADDR) begin
                    full_next  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    address_next = address_reg + ADDR_W'(1);
                    if (i_stop)       state_next = S_IDLE;
                    else if (i_pause) state_next = S_PAUSE;
                    else              state_next = S_WAIT;
                end
            end
            S_PAUSE: begin
                if (i_stop)                 state_next = S_IDLE;
                else if (i_start && !i_pause) state_next = S_WAIT;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign o_address   = address_reg;
    assign o_data      = data_reg;
    assign o_last_addr = last_reg;
    assign o_full      = full_reg;
    assign o_wr        = (state_reg == S_WRITE);
    assign o_busy      = (state_reg == S_WAIT) || (state_reg == S_SHIFT) || (state_reg == S_WRITE);
    assign o_paused    = (state_reg == S_PAUSE);
endmodule

// File: tb/tb_aud_recorder.sv
// Bench for aud_recorder: random I2S frames against a frame-level model of the recorder.
`timescale 1ns/1ps
module tb_aud_recorder;
    import aud_pkg::*;

    localparam int AW = 20;
    localparam int SW = 16;
    localparam int M_IDLE  = 0;
    localparam int M_REC   = 1;
    localparam int M_PAUSE = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lrc = 1'b1;
    logic din = 1'b0;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic stop = 1'b0;

    logic [AW-1:0] addr [2];
    logic [SW-1:0] dat  [2];
    logic          wr   [2];
    logic          busy [2];
    logic          pausd[2];
    logic          full [2];
    logic [AW-1:0] last [2];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // dut0 uses the full address space, dut1 a tiny one to reach the full condition.
    aud_recorder dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(din),
        .i_start(start), .i_pause(pause), .i_stop(stop),
        .o_address(addr[0]), .o_data(dat[0]), .o_wr(wr[0]), .o_busy(busy[0]),
        .o_paused(pausd[0]), .o_full(full[0]), .o_last_addr(last[0])
    );

    aud_recorder #(.MAX_ADDR(20'd7)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(din),
        .i_start(start), .i_pause(pause), .i_stop(stop),
        .o_address(addr[1]), .o_data(dat[1]), .o_wr(wr[1]), .o_busy(busy[1]),
        .o_paused(pausd[1]), .o_full(full[1]), .o_last_addr(last[1])
    );

    typedef struct {
        int            c;
        logic [AW-1:0] a;
        logic [SW-1:0] d;
    } wr_t;

    wr_t exp_q [2][$];
    wr_t obs_q [2][$];
    int   dbl     [2] = '{0, 0};
    logic prev_wr [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (wr[m]) begin
                obs_q[m].push_back('{cyc, addr[m], dat[m]});
                if (prev_wr[m]) dbl[m] <= dbl[m] + 1;
            end
            prev_wr[m] <= wr[m];
        end
    end

    // Recorder model: mode, next address, last written address, full flag.
    int            mode [2];
    logic [AW-1:0] nxt  [2];
    logic [AW-1:0] lst  [2];
    logic          fl   [2];
    logic [AW-1:0] maxa [2];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int m, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, m, o, e);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mode[m] = M_IDLE;
            nxt[m]  = '0;
            lst[m]  = '0;
            fl[m]   = 1'b0;
        end
    endtask

    task automatic check_zero(input string tag);
        for (int m = 0; m < 2; m++)
            chk(tag, m, 64'({addr[m], dat[m], wr[m], busy[m], pausd[m], full[m], last[m]}), 64'd0);
    endtask

    task automatic check_state(input string tag);
        wr_t o, e;
        for (int m = 0; m < 2; m++) begin
            chk({tag, "_busy"},   m, 64'(busy[m]),  64'(mode[m] == M_REC));
            chk({tag, "_paused"}, m, 64'(pausd[m]), 64'(mode[m] == M_PAUSE));
            chk({tag, "_full"},   m, 64'(full[m]),  64'(fl[m]));
            chk({tag, "_last"},   m, 64'(last[m]),  64'(lst[m]));
            chk({tag, "_addr"},   m, 64'(addr[m]),  64'(nxt[m]));
            chk({tag, "_wr_count"}, m, 64'(obs_q[m].size()), 64'(exp_q[m].size()));
            while (obs_q[m].size() > 0 && exp_q[m].size() > 0) begin
                o = obs_q[m].pop_front();
                e = exp_q[m].pop_front();
                $display("wr dut%0d cyc=%0d addr=%0h data=%04h", m, o.c, o.a, o.d);
                chk({tag, "_wr_cyc"},  m, 64'(o.c), 64'(e.c));
                chk({tag, "_wr_addr"}, m, 64'(o.a), 64'(e.a));
                chk({tag, "_wr_data"}, m, 64'(o.d), 64'(e.d));
            end
            obs_q[m].delete();
            exp_q[m].delete();
            chk({tag, "_wr_b2b"}, m, 64'(dbl[m]), 64'd0);
        end
    endtask

    // One 64-cycle LRC period: left word in bits 1..16 after the falling edge, noise elsewhere.
    // Pulse/reset positions are cycle indices within the frame (-1 = none).
    task automatic frame(input logic [SW-1:0] word, input int st, input int pa, input int sp, input int rs);
        int e;
        bit cap [2];
        e = 0;
        for (int m = 0; m < 2; m++) cap[m] = (mode[m] == M_REC);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i == rs + 2) rst_n = 1'b1;
            if (i == 0) e = cyc;
            lrc   = (i >= 32);
            din   = (i >= 1 && i <= 16) ? word[16-i] : 1'($urandom);
            start = (i == st);
            pause = (i == pa);
            stop  = (i == sp);
            for (int m = 0; m < 2; m++) begin
                if (i == 17 && cap[m]) begin
                    exp_q[m].push_back('{e + 17, nxt[m], word});
                    lst[m] = nxt[m];
                    if (nxt[m] == maxa[m]) begin
                        fl[m]   = 1'b1;
                        mode[m] = M_IDLE;
                    end else begin
                        nxt[m] = nxt[m] + 1'b1;
                    end
                end
                if (i == sp) begin
                    mode[m] = M_IDLE;
                    cap[m]  = 1'b0;
                end else if (i == pa) begin
                    if (mode[m] == M_REC) begin
                        mode[m] = M_PAUSE;
                        cap[m]  = 1'b0;
                    end
                end else if (i == st) begin
                    if (mode[m] == M_IDLE) begin
                        mode[m] = M_REC;
                        nxt[m]  = '0;
                        lst[m]  = '0;
                        fl[m]   = 1'b0;
                    end else if (mode[m] == M_PAUSE) begin
                        mode[m] = M_REC;
                    end
                end
            end
            if (i == rs) begin
                #1 rst_n = 1'b0;
                #1 check_zero("async_reset");
                model_reset();
                cap[0] = 1'b0;
                cap[1] = 1'b0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        maxa[0] = 20'hFFFFF;
        maxa[1] = 20'd7;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Basic capture: known word at address 0, next frame at address 1.
        frame(16'($urandom), 40, -1, -1, -1);   check_state("s1_start");
        frame(16'hA5C3, -1, -1, -1, -1);        check_state("s1_a5c3");
        frame(16'($urandom), -1, -1, -1, -1);   check_state("s1_next");

        // Stop while waiting, restart, four words, pause mid-shift, resume mid-frame.
        frame(16'($urandom), -1, -1, 20, -1);   check_state("s2_stop_wait");
        frame(16'($urandom), 40, -1, -1, -1);   check_state("s2_start");
        for (int k = 1; k <= 4; k++) begin
            frame(16'(k), -1, -1, -1, -1);      check_state("s2_word");
        end
        frame(16'($urandom), -1, 8, -1, -1);    check_state("s2_pause_shift");
        frame(16'($urandom), -1, -1, -1, -1);   check_state("s2_paused");
        frame(16'($urandom), 5, -1, -1, -1);    check_state("s2_resume_mid");
        frame(16'($urandom), -1, -1, -1, -1);   check_state("s2_after_resume");

        // Complete ten writes, stop mid-shift, restart at address 0.
        for (int k = 0; k < 5; k++) begin
            frame(16'($urandom), -1, -1, -1, -1); check_state("s3_word");
        end
        frame(16'($urandom), -1, -1, 9, -1);    check_state("s3_stop_shift");
        frame(16'($urandom), 40, -1, -1, -1);   check_state("s3_restart");
        frame(16'($urandom), -1, -1, -1, -1);   check_state("s3_first");

        // Fill the small instance to its last address, then restart.
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_zero("s4_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        frame(16'($urandom), 40, -1, -1, -1);   check_state("s4_start");
        for (int k = 0; k < 10; k++) begin
            frame(16'($urandom), -1, -1, -1, -1); check_state("s4_fill");
        end
        frame(16'($urandom), 40, -1, -1, -1);   check_state("s4_restart");
        frame(16'($urandom), -1, -1, -1, -1);   check_state("s4_after_full");

        // Stop beats pause; pause in the write cycle still writes.
        frame(16'($urandom), -1, 40, 40, -1);   check_state("s5_stop_pause");
        frame(16'($urandom), 40, -1, -1, -1);   check_state("s5_start");
        frame(16'($urandom), -1, 17, -1, -1);   check_state("s5_pause_write");

        // Asynchronous reset mid-shift, then nothing until a start.
        frame(16'($urandom), 40, -1, -1, -1);   check_state("s6_resume");
        frame(16'($urandom), -1, -1, -1, 8);    check_state("s6_reset_shift");
        frame(16'($urandom), -1, -1, -1, -1);   check_state("s6_idle1");
        frame(16'($urandom), -1, -1, -1, -1);   check_state("s6_idle2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aud_recorder.md
Name: aud_recorder

Overview:
- Capture stage between the WM8731 codec ADC serial output and the SRAM write port of the recorder/player top.
- Deserializes one I2S channel (16-bit, MSB first, one-bit delay after the LRC edge) on the codec bit clock.
- Emits one SRAM write strobe per captured sample, with an auto-incrementing address.
- Implements record / pause / stop control and reports the end address used by the player.

Parameters:
- SAMPLE_W, 16: bits per sample captured and written.
- ADDR_W, 20: SRAM word address width.
- MAX_ADDR, 20'hFFFFF: last writable address; a write here ends recording with full.
- CAPTURE_LRC, 1'b0: LRC level of the captured channel (0 = left in I2S).

Ports:
- i_clk  in  1  codec bit clock (AUD_BCLK); all logic on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_lrc  in  1  ADC LR clock (AUD_ADCLRCK).
- i_data  in  1  ADC serial data (AUD_ADCDAT).
- i_start  in  1  one-cycle pulse: start new recording or resume from pause.
- i_pause  in  1  one-cycle pulse: pause.
- i_stop  in  1  one-cycle pulse: stop.
- o_address  out  ADDR_W  SRAM address of the current or next write.
- o_data  out  SAMPLE_W  sample to write; stable from the o_wr cycle until the next o_wr.
- o_wr  out  1  one-cycle write strobe.
- o_busy  out  1  high in WAIT/SHIFT/WRITE.
- o_paused  out  1  high in PAUSE.
- o_full  out  1  sticky; set when MAX_ADDR has been written.
- o_last_addr  out  ADDR_W  address of the last sample written in the current or most recent recording.

Behaviour:
- Reset (async, i_rst_n=0):
  - state IDLE.
  - o_address=0, o_data=0, o_wr=0, o_busy=0, o_paused=0, o_full=0, o_last_addr=0.
  - lrc_d=0, bit counter=0.
- lrc_d is a registered copy of i_lrc, updated every cycle in every state.
- Capture edge: cycle E where i_lrc != lrc_d && i_lrc == CAPTURE_LRC.
- States:
  - IDLE: waits for i_start. Start → WAIT, o_address=0, o_full=0, o_last_addr=0.
  - WAIT: capture edge → SHIFT, counter=0. i_data at E is the I2S delay slot and is ignored.
  - SHIFT: cycles E+1..E+SAMPLE_W shift i_data in MSB first. After the SAMPLE_W-th bit → WRITE.
  - WRITE: cycle E+SAMPLE_W+1. o_wr=1, o_data=assembled sample, o_address=target. o_last_addr←o_address.
    - If o_address==MAX_ADDR → IDLE with o_full=1; o_address stays at MAX_ADDR.
    - Otherwise o_address+1 → WAIT.
  - PAUSE: retains o_address, o_last_addr and o_data. i_start → WAIT (resume at o_address, no reset).
- Priority when pulses coincide: stop > pause > start.
- i_stop in any non-IDLE state → IDLE.
  - o_address and o_last_addr are held for the player.
  - A stop in WRITE still completes that write first: o_wr is asserted and the address is recorded.
  - A stop in SHIFT discards the partial sample.
- i_pause:
  - In WAIT/SHIFT → PAUSE; a partial sample is discarded.
  - In WRITE → the write completes, then PAUSE instead of WAIT.
  - Ignored in IDLE/PAUSE.
- i_start:
  - In WAIT/SHIFT/WRITE: ignored.
  - In IDLE with o_full=1: clears o_full and restarts at address 0.
- Resume from PAUSE mid-frame: no capture until the next capture edge, so no misaligned samples.
- o_wr is never high for two consecutive cycles. Minimum spacing is SAMPLE_W+2 cycles; one per LRC period in normal operation.
- Widths:
  - Address increments unsigned, no wrap (terminates at MAX_ADDR).
  - The shifter is SAMPLE_W bits; extra bits in a longer frame are ignored.

Decomposition:
- Shared package aud_pkg holds:
  - enum rec_state_t {S_IDLE, S_WAIT, S_SHIFT, S_WRITE, S_PAUSE}.
  - localparams SAMPLE_W and ADDR_W defaults, reused by the player.
- One sub-module, aud_i2s_shift:
  - Contains the lrc_d register, capture-edge detect, bit counter and shift register.
  - Outputs o_sample plus a one-cycle o_done.
  - Enabled/cleared by the FSM in aud_recorder.

Test Plan:
- Reset then start; LRC period 64 cycles; left word 16'hA5C3 with bit 15 one cycle after the LRC falling edge → o_wr at E+17, o_address=0, o_data=16'hA5C3; next write at address 1 after 64 cycles.
- 4 samples 16'h0001..16'h0004 written, then i_pause mid-SHIFT of the 5th, start 100 cycles later → no write while paused; next write at address 4 with the first full word after a fresh LRC edge; o_last_addr=3 during the pause.
- i_stop during SHIFT after 10 writes → no further o_wr; o_last_addr=9; o_busy=0. A new start → first write at address 0.
- MAX_ADDR overridden to 7, record 10 frames → exactly 8 writes (0..7), then o_full=1, IDLE, o_last_addr=7. Start again → o_full clears and writing restarts at 0.
- i_stop and i_pause in the same cycle during WAIT → IDLE, not PAUSE. i_pause in the WRITE cycle → write occurs, then PAUSE.
- Assert i_rst_n low mid-SHIFT → all outputs 0 asynchronously. After release, idle with no writes until a start pulse.
